mult_reservation_station: RTL

- Reservation station feeding multiplier_functional_unit; holds MUL/MULH ops between dispatch and execute.
- Captures operand values from CDB broadcasts, tracks age, issues oldest ready entry when the FU is idle.
- Supplies the execute packet and the RS tag that the FU returns on the CDB.

---
 rtl/mult_reservation_station_pkg.sv | 29 ++
 rtl/rs_age_matrix.sv | 52 +++++
 rtl/mult_reservation_station.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mult_reservation_station_pkg.sv
// rtl/mult_reservation_station_pkg.sv - shared types and constants for the multiplier reservation station
package mult_reservation_station_pkg;

    localparam logic [3:0] MULT_RS_TAG_BASE = 4'd9;
    localparam logic [3:0] TAG_READY        = 4'd0;
    localparam logic [3:0] OP_MUL           = 4'b0011;
    localparam logic [3:0] OP_MULH          = 4'b0100;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [4:0]  dest;
    } reservation_station_s;

    typedef struct packed {
        logic        valid;
        logic [3:0]  tag;
        logic [31:0] data;
    } cdb_packet_s;

    // True when a broadcast satisfies an operand that is still waiting on tag q.
    function automatic logic cdb_match(input cdb_packet_s cdb, input logic [3:0] q);
        return cdb.valid && (q != TAG_READY) && (cdb.tag == q);
    endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// rtl/rs_age_matrix.sv - age matrix picking the oldest ready entry of a reservation station
module rs_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [DEPTH-1:0] alloc_i,
    input  logic [DEPTH-1:0] free_i,
    input  logic [DEPTH-1:0] ready_i,
    output logic [DEPTH-1:0] oldest_o
);

    // older_q[i][j] set means entry i was allocated before entry j.
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] blocked;

    // A new entry is younger than everything present; freed entries drop all relations.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (free_i[i] || free_i[j]) begin
                        older_q[i][j] <= 1'b0;
                    end else if (alloc_i[j] && (i != j)) begin
                        older_q[i][j] <= 1'b1;
                    end else if (alloc_i[i]) begin
                        older_q[i][j] <= 1'b0;
                    end
                end
            end
        end
    end

    // An entry is oldest when no other ready entry is older than it.
    always_comb begin
        blocked  = '0;
        oldest_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (ready_i[j] && older_q[j][i]) begin
                    blocked[i] = 1'b1;
                end
            end
            oldest_o[i] = ready_i[i] && !blocked[i];
        end
    end

endmodule

// File: rtl/mult_reservation_station.sv
// rtl/mult_reservation_station.sv - reservation station holding MUL/MULH ops ahead of the multiplier unit
module mult_reservation_station
    import mult_reservation_station_pkg::*;
#(
    parameter int         NUM_ENTRIES = 4,
    parameter logic [3:0] TAG_BASE    = MULT_RS_TAG_BASE
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             flush_i,
    input  logic                             dispatch_valid_i,
    input  reservation_station_s             dispatch_packet_i,
    output logic                             dispatch_ready_o,
    input  cdb_packet_s                      cdb_i,
    input  logic                             fu_busy_i,
    output logic                             execute_valid_o,
    output reservation_station_s             execute_packet_o,
    output logic [3:0]                       rs_tag_o,
    output logic [$clog2(NUM_ENTRIES):0]     count_o
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

    logic [NUM_ENTRIES-1:0] valid_q;
    reservation_station_s   entry_q [NUM_ENTRIES];
    logic [CNT_W-1:0]       count_q;

    logic [NUM_ENTRIES-1:0] ready_vec;
    logic [NUM_ENTRIES-1:0] alloc_onehot;
    logic [NUM_ENTRIES-1:0] oldest_onehot;
    logic [NUM_ENTRIES-1:0] issue_onehot;
    logic [NUM_ENTRIES-1:0] age_alloc;
    logic [NUM_ENTRIES-1:0] age_free;
    logic [IDX_W-1:0]       sel_idx;
    logic                   dispatch_fire;
    logic                   issue_fire;
    reservation_station_s   disp_pkt;

    // Readiness only looks at stored state, so a wakeup becomes issuable one cycle later.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            ready_vec[i] = valid_q[i] && (entry_q[i].qj == TAG_READY) && (entry_q[i].qk == TAG_READY);
        end
    end

    // Lowest-index free slot; the descending scan lets the lowest index win.
    always_comb begin
        alloc_onehot = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_onehot    = '0;
                alloc_onehot[i] = 1'b1;
            end
        end
    end

    assign dispatch_ready_o = !(&valid_q);
    assign dispatch_fire    = dispatch_valid_i && dispatch_ready_o && !flush_i;
    assign execute_valid_o  = (|ready_vec) && !fu_busy_i && !flush_i;
    assign issue_fire       = execute_valid_o;
    assign issue_onehot     = issue_fire ? oldest_onehot : '0;
    assign age_alloc        = dispatch_fire ? alloc_onehot : '0;
    assign age_free         = flush_i ? '1 : issue_onehot;
    assign count_o          = count_q;

    rs_age_matrix #(
        .DEPTH (NUM_ENTRIES)
    ) u_age (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .alloc_i   (age_alloc),
        .free_i    (age_free),
        .ready_i   (ready_vec),
        .oldest_o  (oldest_onehot)
    );

    // Operands arriving on the CDB in the dispatch cycle are captured as they are written.
    always_comb begin
        disp_pkt = dispatch_packet_i;
        if (cdb_match(cdb_i, dispatch_packet_i.qj)) begin
            disp_pkt.vj = cdb_i.data;
            disp_pkt.qj = TAG_READY;
        end
        if (cdb_match(cdb_i, dispatch_packet_i.qk)) begin
            disp_pkt.vk = cdb_i.data;
            disp_pkt.qk = TAG_READY;
        end
    end

    // Encode the selected entry's index for the packet mux and tag.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (oldest_onehot[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Issue outputs are zero unless a request is being presented to the FU.
    always_comb begin
        execute_packet_o = '0;
        rs_tag_o         = TAG_READY;
        if (execute_valid_o) begin
            execute_packet_o    = entry_q[sel_idx];
            execute_packet_o.qj = TAG_READY;
            execute_packet_o.qk = TAG_READY;
            rs_tag_o            = TAG_BASE + 4'(sel_idx);
        end
    end

    // Entry storage: issue frees, dispatch writes, CDB wakes up waiting operands.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (issue_onehot[i]) begin
                    valid_q[i] <= 1'b0;
                end else if (dispatch_fire && alloc_onehot[i]) begin
                    valid_q[i] <= 1'b1;
                    entry_q[i] <= disp_pkt;
                end else if (valid_q[i]) begin
                    if (cdb_match(cdb_i, entry_q[i].qj)) begin
                        entry_q[i].vj <= cdb_i.data;
                        entry_q[i].qj <= TAG_READY;
                    end
                    if (cdb_match(cdb_i, entry_q[i].qk)) begin
                        entry_q[i].vk <= cdb_i.data;
                        entry_q[i].qk <= TAG_READY;
                    end
                end
            end
        end
    end

    // Occupancy counter; a simultaneous dispatch and issue leave it unchanged.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else if (flush_i) begin
            count_q <= '0;
        end else begin
            case ({dispatch_fire, issue_fire})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
